// File: rtl/mul4_fitness_scorer.sv
`default_nettype none
// ============================================================================
// Module   : mul4_fitness_scorer
// Purpose  : Scores a bit-sliced 2x2 multiplier candidate against the golden
//            product, accumulating matching output bits over a run of beats.
// Revision : 1.0  initial release
// ============================================================================
module mul4_fitness_scorer #(
    parameter int NUM_BEATS = 4,
    parameter int SCORE_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        a1,
    input  logic [15:0]        a0,
    input  logic [15:0]        b1,
    input  logic [15:0]        b0,
    input  logic [15:0]        y3,
    input  logic [15:0]        y2,
    input  logic [15:0]        y1,
    input  logic [15:0]        y0,
    output logic               busy,
    output logic               done_valid,
    input  logic               done_ready,
    output logic [SCORE_W-1:0] score,
    output logic               perfect
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_DRAIN  = 2'd2;
    localparam logic [1:0] c_REPORT = 2'd3;

    localparam logic [7:0]         c_LAST_BEAT  = 8'(NUM_BEATS - 1);
    localparam logic [SCORE_W-1:0] c_FULL_SCORE = SCORE_W'(64 * NUM_BEATS);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [7:0]         r_beat_cnt;
    logic [6:0]         r_hits;
    logic [6:0]         w_hits;
    logic               r_s1_valid;
    logic [SCORE_W-1:0] r_acc;
    logic [SCORE_W-1:0] w_acc_sum;
    logic [SCORE_W-1:0] r_score;
    logic               r_perfect;
    logic               w_xfer;
    logic               w_last_xfer;
    logic               w_in_ready;
    logic               w_busy;
    logic               w_done_valid;
    logic [3:0]         w_prod;
    logic [3:0]         w_cand;
    logic [3:0]         w_match;

    // Per lane: golden 2x2 product versus candidate nibble, count equal bits.
    always_comb begin
        w_hits  = '0;
        w_prod  = '0;
        w_cand  = '0;
        w_match = '0;
        for (int i = 0; i < 16; i++) begin
            w_prod  = 4'({a1[i], a0[i]}) * 4'({b1[i], b0[i]});
            w_cand  = {y3[i], y2[i], y1[i], y0[i]};
            w_match = ~(w_prod ^ w_cand);
            for (int k = 0; k < 4; k++) begin
                w_hits = w_hits + 7'(w_match[k]);
            end
        end
    end

    assign w_xfer      = in_valid && w_in_ready;
    assign w_last_xfer = w_xfer && (r_beat_cnt == c_LAST_BEAT);
    assign w_acc_sum   = r_s1_valid ? (r_acc + SCORE_W'(r_hits)) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (start)       w_state_next = c_RUN;
            c_RUN:    if (w_last_xfer) w_state_next = c_DRAIN;
            c_DRAIN:                   w_state_next = c_REPORT;
            c_REPORT: if (done_ready)  w_state_next = c_IDLE;
            default:                   w_state_next = c_IDLE;
        endcase
    end

    // Handshake outputs decode the state register only, so in_ready never
    // depends combinationally on in_valid or done_ready.
    always_comb begin
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_done_valid = 1'b0;
        case (r_state)
            c_RUN: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            c_DRAIN:  w_busy       = 1'b1;
            c_REPORT: w_done_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_hits     <= '0;
            r_s1_valid <= 1'b0;
            r_acc      <= '0;
            r_score    <= '0;
            r_perfect  <= 1'b0;
        end else begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_hits     <= w_hits;
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if (r_state == c_IDLE && start) begin
                r_acc      <= '0;
                r_beat_cnt <= '0;
            end else begin
                r_acc <= w_acc_sum;
            end
            // Result registers only move when a run completes, so they hold
            // through REPORT and across the following IDLE.
            if (r_state == c_DRAIN) begin
                r_score   <= w_acc_sum;
                r_perfect <= (w_acc_sum == c_FULL_SCORE);
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign busy       = w_busy;
    assign done_valid = w_done_valid;
    assign score      = r_score;
    assign perfect    = r_perfect;

endmodule
`default_nettype wire

// File: tb/tb_mul4_fitness_scorer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul4_fitness_scorer
// Purpose  : Self-checking bench for mul4_fitness_scorer (table + scoreboard).
// Revision : 1.0  initial release
// ============================================================================
module tb_mul4_fitness_scorer;

    localparam int NB = 4;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready;
    logic [15:0]   a1, a0, b1, b0, y3, y2, y1, y0;
    logic          busy, done_valid, done_ready, perfect;
    logic [SW-1:0] score;

    always #5 clk = ~clk;

    mul4_fitness_scorer #(.NUM_BEATS(NB), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0), .busy(busy),
        .done_valid(done_valid), .done_ready(done_ready),
        .score(score), .perfect(perfect)
    );

    typedef struct {
        logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
        int          hits;
    } beat_t;

    beat_t tbl[12];
    beat_t cur[NB];
    int    exp_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic beat_t mk(input logic [15:0] v3, v2, v1, v0, input int h);
        beat_t b;
        b.a1 = 16'hCCCC; b.a0 = 16'hAAAA; b.b1 = 16'hFF00; b.b0 = 16'hF0F0;
        b.y3 = v3; b.y2 = v2; b.y1 = v1; b.y0 = v0;
        b.hits = h;
        return b;
    endfunction

    // Reference: per-lane unsigned 2x2 multiply, count equal output bits.
    function automatic int model_hits(input beat_t b);
        int h = 0;
        int av, bv;
        logic [3:0] pv, yv;
        for (int i = 0; i < 16; i++) begin
            av = 2 * int'(b.a1[i]) + int'(b.a0[i]);
            bv = 2 * int'(b.b1[i]) + int'(b.b0[i]);
            pv = 4'(av * bv);
            yv = {b.y3[i], b.y2[i], b.y1[i], b.y0[i]};
            for (int k = 0; k < 4; k++) if (pv[k] == yv[k]) h++;
        end
        return h;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_done_valid"}, 32'(done_valid), 0);
        check({tag, "_score"},      32'(score),      0);
        check({tag, "_perfect"},    32'(perfect),    0);
    endtask

    task automatic drive_run(input int gap, input bit mid_start, input bit abort2);
        int  sum = 0;
        bit  xfer;
        bit  seen_dv;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (abort2 && k == 2) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_reset_vals("abort");
                seen_dv = 1'b0;
                for (int c = 0; c < 8; c++) begin
                    tick();
                    if (done_valid) seen_dv = 1'b1;
                end
                check("abort_no_done", 32'(seen_dv), 0);
                return;
            end
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            a1 = cur[k].a1; a0 = cur[k].a0; b1 = cur[k].b1; b0 = cur[k].b0;
            y3 = cur[k].y3; y2 = cur[k].y2; y1 = cur[k].y1; y0 = cur[k].y0;
            if (mid_start && k == 1) start = 1'b1;
            sum += cur[k].hits;
            xfer = 1'b0;
            for (int w = 0; w < 20 && !xfer; w++) begin
                xfer = in_ready;
                tick();
                start = 1'b0;
            end
            if (!xfer) check("xfer_timeout", 0, 1);
        end
        in_valid = 1'b0;
        exp_q.push_back(sum);
        check("drain_done_valid", 32'(done_valid), 0);
        check("drain_in_ready",   32'(in_ready),   0);
        check("drain_busy",       32'(busy),       1);
        tick();
        check("latency_done_valid", 32'(done_valid), 1);
    endtask

    task automatic collect(input int ready_delay, input bit start_in_report, input bit start_with_ready);
        int exp;
        bit stable = 1'b1;
        int w = 0;
        while (!done_valid && w < 20) begin
            tick();
            w++;
        end
        if (!done_valid) check("done_timeout", 0, 1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        exp = exp_q.pop_front();
        check("score",   32'(score),   32'(exp));
        check("perfect", 32'(perfect), 32'(exp == 64 * NB));
        for (int d = 0; d < ready_delay; d++) begin
            if (start_in_report && d == 1) start = 1'b1;
            tick();
            start = 1'b0;
            if (!(done_valid && int'(score) == exp && perfect == (exp == 64 * NB) && !in_ready))
                stable = 1'b0;
        end
        if (ready_delay > 0) check("report_hold_stable", 32'(stable), 1);
        done_ready = 1'b1;
        if (start_with_ready) start = 1'b1;
        tick();
        done_ready = 1'b0;
        start      = 1'b0;
        check("retire_done_valid", 32'(done_valid), 0);
        check("retire_score_hold", 32'(score), 32'(exp));
        check("retire_busy",       32'(busy), 0);
        tick();
        check("idle_in_ready", 32'(in_ready), 0);
    endtask

    task automatic load_golden();
        for (int k = 0; k < NB; k++) cur[k] = tbl[0];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0, 64);
        tbl[1]  = tbl[0];
        tbl[2]  = tbl[0];
        tbl[3]  = tbl[0];
        tbl[4]  = tbl[0];
        tbl[5]  = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 50);
        tbl[6]  = tbl[0];
        tbl[7]  = tbl[0];
        tbl[8]  = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 14);
        tbl[9]  = mk(16'h8000, 16'h4C00, 16'h6AC0, 16'h5F5F, 48);
        tbl[10] = mk(16'h0000, 16'h4C00, 16'h6AC0, 16'hA0A0, 63);
        tbl[11] = tbl[0];

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; done_ready = 1'b0;
        a1 = '0; a0 = '0; b1 = '0; b0 = '0; y3 = '0; y2 = '0; y1 = '0; y0 = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_vals("reset");

        // Table runs: exact, one zeroed beat, mixed faults.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NB; k++) cur[k] = tbl[r * NB + k];
            drive_run(0, 1'b0, 1'b0);
            collect(0, 1'b0, 1'b0);
        end

        // Input gaps and held-off result acceptance.
        load_golden();
        drive_run(2, 1'b0, 1'b0);
        collect(5, 1'b0, 1'b0);

        // Start pulses in RUN and REPORT, retire with start+done_ready.
        load_golden();
        drive_run(0, 1'b1, 1'b0);
        collect(3, 1'b1, 1'b1);

        // Abort after two beats, then a clean run.
        load_golden();
        drive_run(0, 1'b0, 1'b1);
        drive_run(0, 1'b0, 1'b0);
        collect(0, 1'b0, 1'b0);

        // Random operands and candidates against the reference model.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NB; k++) begin
                cur[k].a1 = 16'($urandom); cur[k].a0 = 16'($urandom);
                cur[k].b1 = 16'($urandom); cur[k].b0 = 16'($urandom);
                cur[k].y3 = 16'($urandom); cur[k].y2 = 16'($urandom);
                cur[k].y1 = 16'($urandom); cur[k].y0 = 16'($urandom);
                cur[k].hits = model_hits(cur[k]);
            end
            drive_run(r, 1'b0, 1'b0);
            collect(r, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
